// File: rtl/mem_test_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_test_sequencer_pkg: FSM state and pattern-mode encodings         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_test_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WRITE   = 3'd1;
  localparam state_t ST_READ    = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam logic [1:0] MODE_INCR    = 2'd0;
  localparam logic [1:0] MODE_ADDR    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_WALK1   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_test_sequencer_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mts_pattern_gen: combinational test pattern pat(i, addr, mode)       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mts_pattern_gen import mem_test_sequencer_pkg::*; #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] pat_o
);

  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] walk;

  always_comb begin
    chk = '0;
    // Even index gives ...1010, odd index gives ...0101
    for (int k = 0; k < DATA_W; k++) begin
      chk[k] = ((k % 2) == 1) ^ idx_i[0];
    end
    walk = DATA_W'(1) << (32'(idx_i) % DATA_W);
  end

  always_comb begin
    pat_o = '0;
    case (mode_i)
      MODE_INCR:    pat_o = DATA_W'(idx_i);
      MODE_ADDR:    pat_o = DATA_W'(addr_i);
      MODE_CHECKER: pat_o = chk;
      default:      pat_o = walk;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_test_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_test_sequencer: write/read-back memory test with pass/fail count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_test_sequencer import mem_test_sequencer_pkg::*; #(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned DATA_W    = 2,
  parameter int unsigned NUM_ADDR  = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              fail_seen
);

  localparam int unsigned      IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ADDR - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [ADDR_W-1:0]  ffa_q, ffa_d;
  logic               seen_q, seen_d;

  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  pat;
  logic               last;

  assign cur_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
  assign last     = (idx_q == LAST_IDX);

  mts_pattern_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_pattern_gen (
    .idx_i  (idx_q),
    .addr_i (cur_addr),
    .mode_i (mode_q),
    .pat_o  (pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start)     state_d = ST_WRITE;
      ST_WRITE:   if (req_ready && last) state_d = ST_READ;
      ST_READ:    if (req_ready)       state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rsp_valid)       state_d = last ? ST_DONE : ST_READ;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state_q == ST_WRITE) || (state_q == ST_READ);
    req_we    = (state_q == ST_WRITE);
    busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_RD_WAIT);
    done      = (state_q == ST_DONE);
    // Bus fields read as zero whenever no request is presented
    req_addr  = req_valid ? cur_addr : '0;
    req_wdata = req_we ? pat : '0;
  end

  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    pass_d = pass_q;
    fail_d = fail_q;
    ffa_d  = ffa_q;
    seen_d = seen_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d = mode;
          idx_d  = '0;
          pass_d = '0;
          fail_d = '0;
          ffa_d  = '0;
          seen_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (req_ready) idx_d = last ? '0 : idx_q + IDX_W'(1);
      end
      ST_RD_WAIT: begin
        if (rsp_valid) begin
          if (rsp_rdata == pat) begin
            pass_d = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
          end else begin
            fail_d = (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
            if (!seen_q) begin
              seen_d = 1'b1;
              ffa_d  = cur_addr;
            end
          end
          idx_d = last ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      mode_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ffa_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ffa_q  <= ffa_d;
      seen_q <= seen_d;
    end
  end

  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign first_fail_addr = ffa_q;
  assign fail_seen       = seen_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_test_sequencer: scoreboard bench with memory slave models     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_test_sequencer;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] fault;
    bit         rnd;
    int         pass;
    int         fail;
    bit         seen;
    logic [1:0] ffa;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic       start_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic       req_valid_a, req_we_a;
  logic       req_ready_a = 1'b1;
  logic [1:0] req_addr_a, req_wdata_a;
  logic       rsp_valid_a = 1'b0;
  logic [1:0] rsp_rdata_a = 2'd0;
  logic       busy_a, done_a, fail_seen_a;
  logic [7:0] pass_cnt_a, fail_cnt_a;
  logic [1:0] ffa_a;

  // DATA_W=8, NUM_ADDR=6 DUT
  logic       start_6 = 1'b0;
  logic [1:0] mode_6 = 2'd0;
  logic       req_valid_6, req_we_6;
  logic       req_ready_6 = 1'b1;
  logic [1:0] req_addr_6;
  logic [7:0] req_wdata_6;
  logic       rsp_valid_6 = 1'b0;
  logic [7:0] rsp_rdata_6 = 8'd0;
  logic       busy_6, done_6, fail_seen_6;
  logic [7:0] pass_cnt_6, fail_cnt_6;
  logic [1:0] ffa_6;

  mem_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .busy(busy_a), .done(done_a), .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a),
    .first_fail_addr(ffa_a), .fail_seen(fail_seen_a)
  );

  mem_test_sequencer #(.ADDR_W(2), .DATA_W(8), .NUM_ADDR(6), .BASE_ADDR(0), .CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .start(start_6), .mode(mode_6),
    .req_valid(req_valid_6), .req_ready(req_ready_6), .req_we(req_we_6),
    .req_addr(req_addr_6), .req_wdata(req_wdata_6),
    .rsp_valid(rsp_valid_6), .rsp_rdata(rsp_rdata_6),
    .busy(busy_6), .done(done_6), .pass_cnt(pass_cnt_6), .fail_cnt(fail_cnt_6),
    .first_fail_addr(ffa_6), .fail_seen(fail_seen_6)
  );

  int n_checks = 0;
  int n_fail   = 0;

  req_t sbq_a[$];
  req_t sbq_6[$];

  logic [3:0] fault_a = 4'd0;
  bit         rnd_a   = 1'b0;
  bit         spur_a  = 1'b0;
  int         n_reads_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pat(input logic [1:0] m, input int i, input int addr, input int dw);
    logic [7:0] mask = 8'((1 << dw) - 1);
    logic [7:0] r = 8'd0;
    case (m)
      2'd0: r = 8'(i) & mask;
      2'd1: r = 8'(addr) & mask;
      2'd2: for (int k = 0; k < dw; k++) r[k] = ((k % 2) == 1) ^ ((i % 2) == 1);
      default: r = 8'(1 << (i % dw));
    endcase
    return r;
  endfunction

  task automatic push_exp(input int which, input logic [1:0] m, input int n, input int dw);
    req_t e;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < n; i++) begin
        e.we   = (ph == 0);
        e.addr = 8'(i % 4);
        e.data = (ph == 0) ? exp_pat(m, i, i % 4, dw) : 8'd0;
        if (which == 0) sbq_a.push_back(e);
        else            sbq_6.push_back(e);
      end
    end
  endtask

  // Slave for the default DUT: optional random stalls, response delay, stuck-at-0 bit0 faults
  logic [1:0] mem_a [4];
  bit         rd_pend_a = 1'b0;
  int         rd_dly_a  = 0;
  logic [1:0] rd_data_a = 2'd0;
  bit         stall_a   = 1'b0;
  logic [5:0] stall_vec_a = 6'd0;

  always begin
    req_t e;
    @(posedge clk);
    if (rst) begin
      rd_pend_a = 1'b0;
      stall_a   = 1'b0;
    end else begin
      if (stall_a) check("stall_hold", 64'({req_valid_a, req_we_a, req_addr_a, req_wdata_a}), 64'(stall_vec_a));
      stall_a     = req_valid_a && !req_ready_a;
      stall_vec_a = {req_valid_a, req_we_a, req_addr_a, req_wdata_a};
      if (req_valid_a && req_ready_a) begin
        if (sbq_a.size() == 0) begin
          check("unexpected_req", 64'({req_we_a, req_addr_a}), 64'hFF);
        end else begin
          e = sbq_a.pop_front();
          check("req_we", 64'(req_we_a), 64'(e.we));
          check("req_addr", 64'(req_addr_a), 64'(e.addr));
          if (e.we) check("req_wdata", 64'(req_wdata_a), 64'(e.data));
        end
        if (req_we_a) begin
          mem_a[req_addr_a] = req_wdata_a;
        end else begin
          rd_pend_a = 1'b1;
          rd_dly_a  = rnd_a ? int'($urandom_range(0, 3)) : 0;
          rd_data_a = mem_a[req_addr_a] & ~{1'b0, fault_a[req_addr_a]};
          n_reads_a++;
        end
      end
    end
    @(negedge clk);
    req_ready_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rd_pend_a && rd_dly_a == 0) begin
      rsp_valid_a = 1'b1;
      rsp_rdata_a = rd_data_a;
      rd_pend_a   = 1'b0;
    end else begin
      if (rd_pend_a) rd_dly_a--;
      rsp_valid_a = spur_a;
      rsp_rdata_a = spur_a ? 2'b11 : 2'b00;
    end
  end

  // Ideal slave for the wide DUT
  logic [7:0] mem_6 [4];
  bit         rd_pend_6 = 1'b0;
  logic [7:0] rd_data_6 = 8'd0;

  always begin
    req_t e;
    @(posedge clk);
    if (rst) begin
      rd_pend_6 = 1'b0;
    end else if (req_valid_6 && req_ready_6) begin
      if (sbq_6.size() == 0) begin
        check("unexpected_req6", 64'({req_we_6, req_addr_6}), 64'hFF);
      end else begin
        e = sbq_6.pop_front();
        check("req6_we", 64'(req_we_6), 64'(e.we));
        check("req6_addr", 64'(req_addr_6), 64'(e.addr));
        if (e.we) check("req6_wdata", 64'(req_wdata_6), 64'(e.data));
      end
      if (req_we_6) mem_6[req_addr_6] = req_wdata_6;
      else begin
        rd_pend_6 = 1'b1;
        rd_data_6 = mem_6[req_addr_6];
      end
    end
    @(negedge clk);
    rsp_valid_6 = rd_pend_6;
    rsp_rdata_6 = rd_data_6;
    rd_pend_6   = 1'b0;
  end

  task automatic pulse_start_a(input logic [1:0] m);
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = m;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = ~m;
  endtask

  task automatic wait_done(input int which, input int budget);
    int c = 0;
    while (((which == 0) ? !done_a : !done_6) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_reached", 64'((which == 0) ? done_a : done_6), 64'd1);
  endtask

  task automatic run_a(input vec_t v, input string tag);
    fault_a   = v.fault;
    rnd_a     = v.rnd;
    n_reads_a = 0;
    push_exp(0, v.mode, 4, 2);
    pulse_start_a(v.mode);
    wait_done(0, 500);
    check({tag, "_pass"}, 64'(pass_cnt_a), 64'(v.pass));
    check({tag, "_fail"}, 64'(fail_cnt_a), 64'(v.fail));
    check({tag, "_seen"}, 64'(fail_seen_a), 64'(v.seen));
    check({tag, "_ffa"},  64'(ffa_a), 64'(v.ffa));
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_sb_empty"}, 64'(sbq_a.size()), 64'd0);
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({req_valid_a, req_we_a, req_addr_a, req_wdata_a, busy_a, done_a,
                pass_cnt_a, fail_cnt_a, ffa_a, fail_seen_a});
  endfunction

  vec_t vecs [5];

  initial begin
    int c;
    //          mode   fault    rnd   pass fail seen ffa
    vecs[0] = '{2'd0, 4'b0000, 1'b0, 4,   0,   1'b0, 2'd0};
    vecs[1] = '{2'd1, 4'b1010, 1'b0, 2,   2,   1'b1, 2'd1};
    vecs[2] = '{2'd0, 4'b0000, 1'b1, 4,   0,   1'b0, 2'd0};
    vecs[3] = '{2'd2, 4'b0010, 1'b1, 3,   1,   1'b1, 2'd1};
    vecs[4] = '{2'd3, 4'b1100, 1'b1, 3,   1,   1'b1, 2'd2};

    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a(), 64'd0);
    check("reset_outs_6", 64'({req_valid_6, req_we_6, req_addr_6, req_wdata_6, busy_6, done_6,
                               pass_cnt_6, fail_cnt_6, ffa_6, fail_seen_6}), 64'd0);
    rst = 1'b0;

    for (int t = 0; t < 5; t++) run_a(vecs[t], $sformatf("vec%0d", t));

    // Reset while waiting for read index 2
    fault_a = 4'd0; rnd_a = 1'b0; n_reads_a = 0;
    push_exp(0, 2'd0, 4, 2);
    pulse_start_a(2'd0);
    c = 0;
    while (n_reads_a < 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("rd_idx2_reached", 64'(n_reads_a), 64'd3);
    check("pass_before_rst", 64'(pass_cnt_a), 64'd2);
    #1 rst = 1'b1;
    #1 check("midrun_rst_outs", outs_a(), 64'd0);
    @(negedge clk);
    sbq_a.delete();
    rst = 1'b0;
    run_a(vecs[0], "after_rst");

    // Start while busy and a stray response during the write phase
    fault_a = 4'd0; rnd_a = 1'b0; n_reads_a = 0;
    push_exp(0, 2'd0, 4, 2);
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = 2'd0;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = 2'd1;
    spur_a  = 1'b1;
    check("busy_in_write", 64'({busy_a, done_a}), 64'b10);
    @(negedge clk);
    spur_a  = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 500);
    check("busy_start_pass", 64'(pass_cnt_a), 64'd4);
    check("busy_start_fail", 64'(fail_cnt_a), 64'd0);
    check("busy_start_sb_empty", 64'(sbq_a.size()), 64'd0);

    // Wide data, more locations than addresses: aliasing on addr 0 and 1
    push_exp(1, 2'd3, 6, 8);
    @(negedge clk);
    start_6 = 1'b1;
    mode_6  = 2'd3;
    @(negedge clk);
    start_6 = 1'b0;
    mode_6  = 2'd0;
    wait_done(1, 500);
    check("w6_pass", 64'(pass_cnt_6), 64'd4);
    check("w6_fail", 64'(fail_cnt_6), 64'd2);
    check("w6_seen", 64'(fail_seen_6), 64'd1);
    check("w6_ffa",  64'(ffa_6), 64'd0);
    check("w6_sb_empty", 64'(sbq_6.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
